uart_stdout_rx: RTL
===================

Name: uart_stdout_rx

Overview:
- Board/testbench-side UART receiver, directly downstream of the SoC top's uart_tx pin; upstream of host stdout logic.
- Deserialises 8N1 frames from the core's UART into bytes.
- Buffers bytes in a small FIFO and presents them on a valid/ready stream.
- Drives the SoC's uart_cts flow-control input so the core stalls before the buffer overflows.

Parameters:
- FIFO_DEPTH, 16, byte buffer entries; power of two, >= 4.
- DIV_WIDTH, 16, width of the baud divisor.
- CTS_MARGIN, 2, free entries at or below which flow control is asserted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  receiver enable; low forces the FSM to IDLE, FIFO contents retained.
- baud_div_i  in  DIV_WIDTH  clock cycles per bit; legal values >= 4.
- rx_i  in  1  serial line, connected to the SoC uart_tx; idle high.
- cts_no  out  1  active-low clear-to-send, connected to the SoC uart_cts.
- data_o  out  8  head byte of the FIFO.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o.
- count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err_o  out  1  sticky: stop bit sampled as 0.
- overflow_o  out  1  sticky: byte dropped because the FIFO was full.
- clr_err_i  in  1  clears both sticky flags; a same-cycle set wins over clear.

Behaviour:
- Reset values: the rx synchroniser flops reset to 1.
  - data_o=0, valid_o=0, count_o=0, frame_err_o=0, overflow_o=0, cts_no=0, FSM=IDLE, FIFO pointers=0.
- rx_i passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rxs=0 and enable_i=1, latch baud_div_i into div_q, load bitcnt=div_q>>1, go to START. The divisor is fixed for the rest of the frame.
  - Bit counter: decrements each cycle; "tick" means bitcnt==1.
  - START: on tick, if rxs=1 (glitch) go to IDLE with nothing pushed. Otherwise reload bitcnt=div_q, bit index=0, go to DATA.
  - DATA: on each tick, shift rxs into the shift register LSB-first and reload bitcnt. After bit 7, go to STOP.
  - STOP: on tick, if rxs=1 push the byte and go to IDLE. If rxs=0 set frame_err_o, discard the byte and go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. Prevents a held-low line from re-triggering.
- enable_i low in any state returns the FSM to IDLE on the next cycle; a partial byte is discarded silently.
- FIFO:
  - Push occurs in the cycle after the stop-bit tick.
  - Pop when valid_o && ready_i.
  - data_o is show-ahead and updates the cycle after a pop.
  - Push while full with no pop: byte dropped, overflow_o set, count unchanged.
  - Push while full with a same-cycle pop: accepted, count unchanged.
  - Push while empty with ready_i high: the byte appears the next cycle; no bypass.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB for the full/empty distinction.
- cts_no is registered: 1 when (FIFO_DEPTH - count) <= CTS_MARGIN, else 0.
- Latency: rx falling edge to valid_o = 2 (sync) + div>>1 + 9*div + 1 cycles.
- Asynchronous reset mid-frame: all state returns to reset values immediately; FIFO contents are lost.

Optional Feature:
- Macro UART_STDOUT_PARITY_EN.
- When defined:
  - Frame is 8E1; a PARITY state sits between DATA and STOP.
  - Even parity is checked against the received bit.
  - On mismatch the byte is discarded and new sticky port parity_err_o (out, 1, reset 0) is set; it is also cleared by clr_err_i.
- When undefined: no PARITY state, no parity_err_o port, 8N1 only.

Decomposition:
- Package uart_stdout_pkg:
  - rx_state_e enum (IDLE, START, DATA, [PARITY,] STOP, BREAK).
  - Constant DATA_BITS=8.
  - Constant MIN_BAUD_DIV=4.
- Sub-module uart_stdout_fifo:
  - Parameterised by depth and width.
  - Contains push/pop, count, full/empty and the overflow pulse.
  - The top handles synchroniser, FSM, flags and CTS.

Test Plan:
- Byte 0x55 at div=16, ready_i=1 -> data_o=0x55, valid_o high exactly 2+8+144+1=155 cycles after the falling edge; frame_err_o=0.
- 3-cycle low glitch on rx_i at div=16 -> FSM returns to IDLE, valid_o stays 0, count_o=0.
- Frame 0xA3 with stop bit 0 -> frame_err_o=1, no push. Line held low 100 cycles then high -> next frame 0x11 received correctly. clr_err_i pulse clears the flag.
- ready_i=0, send 16 bytes 0x00..0x0F -> cts_no goes 1 once count_o=14. 17th byte 0xFF -> overflow_o=1, count_o=16. Drain gives 0x00..0x0F in order.
- Assert rst_n low during DATA bit 4 -> all outputs at reset values. After release, a clean frame 0x7E is received.
- With UART_STDOUT_PARITY_EN: 0x07 with parity bit 1 -> accepted. 0x07 with parity bit 0 -> parity_err_o=1, no push.

Source files
------------

// File: rtl/uart_stdout_pkg.sv
// rtl/uart_stdout_pkg.sv - shared types and constants for the stdout UART receiver
// UART_STDOUT_PARITY_EN adds the PARITY state (8E1 frames).
package uart_stdout_pkg;

   localparam int DATA_BITS    = 8;
   localparam int MIN_BAUD_DIV = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_STDOUT_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_stdout_fifo.sv
// rtl/uart_stdout_fifo.sv - show-ahead byte FIFO with occupancy and overflow pulse
// Pointers carry one extra MSB so full and empty are distinguishable.
module uart_stdout_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             full, empty, do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty;
   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_push = push_i && (!full || do_pop);

   assign overflow_o = push_i && full && !do_pop;
   assign valid_o    = !empty;
   assign count_o    = wr_q - rd_q;
   assign dout_o     = mem_q[rd_q[AW-1:0]];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (do_push) begin
         mem_d[wr_q[AW-1:0]] = din_i;
         wr_d = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/uart_stdout_rx.sv
// rtl/uart_stdout_rx.sv - UART receiver feeding a byte FIFO, with CTS back-pressure
// Define UART_STDOUT_PARITY_EN for 8E1 frames and the parity_err_o flag.
module uart_stdout_rx
   import uart_stdout_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int CTS_MARGIN = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable_i,
   input  logic [DIV_WIDTH-1:0]            baud_div_i,
   input  logic                            rx_i,
   output logic                            cts_no,
   output logic [7:0]                      data_o,
   output logic                            valid_o,
   input  logic                            ready_i,
   output logic [$clog2(FIFO_DEPTH):0]     count_o,
   output logic                            frame_err_o,
   output logic                            overflow_o,
`ifdef UART_STDOUT_PARITY_EN
   output logic                            parity_err_o,
`endif
   input  logic                            clr_err_i
);

   logic [1:0]           sync_q, sync_d;
   rx_state_e            state_q, state_d;
   logic [DIV_WIDTH-1:0] div_q, div_d, bitcnt_q, bitcnt_d, div_in;
   logic [2:0]           bitidx_q, bitidx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 frame_err_q, frame_err_d, overflow_q, overflow_d, cts_q, cts_d;
   logic                 rxs, tick, push, frame_set, fifo_ovf;
`ifdef UART_STDOUT_PARITY_EN
   logic                 par_bad_q, par_bad_d, parity_err_q, parity_err_d, parity_set;
`endif

   assign rxs  = sync_q[1];
   assign tick = (bitcnt_q == DIV_WIDTH'(1));
   // Out-of-range divisors are raised to the minimum rather than producing a zero-length bit.
   assign div_in = (baud_div_i < DIV_WIDTH'(MIN_BAUD_DIV)) ? DIV_WIDTH'(MIN_BAUD_DIV) : baud_div_i;

   always_comb begin
      sync_d    = {sync_q[0], rx_i};
      state_d   = state_q;
      div_d     = div_q;
      bitcnt_d  = (bitcnt_q != '0) ? bitcnt_q - 1'b1 : '0;
      bitidx_d  = bitidx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
`ifdef UART_STDOUT_PARITY_EN
      par_bad_d  = par_bad_q;
      parity_set = 1'b0;
`endif
      if (!enable_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!rxs) begin
                  div_d    = div_in;
                  bitcnt_d = div_in >> 1;
                  state_d  = ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (rxs) begin
                     state_d = ST_IDLE;
                  end else begin
                     bitcnt_d = div_q;
                     bitidx_d = '0;
                     state_d  = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
                  bitcnt_d = div_q;
                  bitidx_d = bitidx_q + 3'd1;
                  if (bitidx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_STDOUT_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end
            end
`ifdef UART_STDOUT_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  bitcnt_d   = div_q;
                  par_bad_d  = (rxs != ^shift_q);
                  parity_set = par_bad_d;
                  state_d    = ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (rxs) begin
`ifdef UART_STDOUT_PARITY_EN
                     push = !par_bad_q;
`else
                     push = 1'b1;
`endif
                     state_d = ST_IDLE;
                  end else begin
                     frame_set = 1'b1;
                     state_d   = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               if (rxs) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      frame_err_d = frame_set | (frame_err_q & ~clr_err_i);
      overflow_d  = fifo_ovf  | (overflow_q  & ~clr_err_i);
`ifdef UART_STDOUT_PARITY_EN
      parity_err_d = parity_set | (parity_err_q & ~clr_err_i);
`endif
      cts_d = (FIFO_DEPTH - int'(count_o)) <= CTS_MARGIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         state_q     <= ST_IDLE;
         div_q       <= '0;
         bitcnt_q    <= '0;
         bitidx_q    <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         cts_q       <= 1'b0;
`ifdef UART_STDOUT_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         div_q       <= div_d;
         bitcnt_q    <= bitcnt_d;
         bitidx_q    <= bitidx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         cts_q       <= cts_d;
`ifdef UART_STDOUT_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign frame_err_o = frame_err_q;
   assign overflow_o  = overflow_q;
   assign cts_no      = cts_q;
`ifdef UART_STDOUT_PARITY_EN
   assign parity_err_o = parity_err_q;
`endif

   uart_stdout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .din_i      (shift_q),
      .pop_i      (valid_o & ready_i),
      .dout_o     (data_o),
      .valid_o    (valid_o),
      .count_o    (count_o),
      .overflow_o (fifo_ovf)
   );

endmodule
